// File: rtl/regfile_wb_queue_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_pkg
// Shared types and constants for the register-file write-back queue.
//   XLEN       : register data width
//   REG_AW     : register address width
//   NREGS      : number of architectural registers (2**REG_AW)
//   wb_entry_t : one queued write {rd, value}
//   onehot_rd  : decodes a register address into a one-hot register mask
// -----------------------------------------------------------------------------
package regfile_wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 3;
    localparam int NREGS  = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   value;
    } wb_entry_t;

    function automatic logic [NREGS-1:0] onehot_rd(input logic [REG_AW-1:0] rd_in);
        logic [NREGS-1:0] one;
        one = {{(NREGS-1){1'b0}}, 1'b1};
        return one << rd_in;
    endfunction

endpackage : regfile_wb_pkg

// File: rtl/regfile_wb_queue_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue_if
// Bundles the producer handshakes (load unit, ALU), the drain stall, the
// register-file write port and the status outputs of the write-back queue.
//   slave  modport : seen by the queue itself
//   master modport : seen by the producers / register file / issue logic
// -----------------------------------------------------------------------------
interface regfile_wb_queue_if #(
    parameter int DEPTH = 4
) ();
    import regfile_wb_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    // load-unit producer
    logic              mem_valid;
    logic              mem_ready;
    logic [REG_AW-1:0] mem_rd;
    logic [XLEN-1:0]   mem_value;
    // ALU producer
    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_value;
    // drain control and register-file write port
    logic              wb_stall;
    logic              reg_write_en;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rd_value;
    // status
    logic [NREGS-1:0]  pending;
    logic [CW-1:0]     count;
    logic              empty;

    modport slave (
        input  mem_valid, mem_rd, mem_value,
        input  alu_valid, alu_rd, alu_value,
        input  wb_stall,
        output mem_ready, alu_ready,
        output reg_write_en, rd, rd_value,
        output pending, count, empty
    );

    modport master (
        output mem_valid, mem_rd, mem_value,
        output alu_valid, alu_rd, alu_value,
        output wb_stall,
        input  mem_ready, alu_ready,
        input  reg_write_en, rd, rd_value,
        input  pending, count, empty
    );

endinterface : regfile_wb_queue_if

// File: rtl/regfile_wb_queue_wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous in-order FIFO of wb_entry_t. Pointers wrap naturally because
// DEPTH is a power of two.
//   clk, reset     : clock, synchronous active-high reset
//   i_push/i_data  : enqueue one entry (caller guarantees !o_full)
//   i_pop          : dequeue the head (caller guarantees o_count != 0)
//   o_head         : entry at the read pointer
//   o_full/o_count : occupancy
//   o_entry_valid  : per-slot occupied flag
//   o_entry_rd     : per-slot destination register tap
// -----------------------------------------------------------------------------
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_push,
    input  wb_entry_t                      i_data,
    input  logic                           i_pop,
    output wb_entry_t                      o_head,
    output logic                           o_full,
    output logic [$clog2(DEPTH):0]         o_count,
    output logic [DEPTH-1:0]               o_entry_valid,
    output logic [DEPTH-1:0][REG_AW-1:0]   o_entry_rd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    wb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_off;

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care once the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (!reset && i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // A slot is occupied when its distance from the read pointer is below count.
    always_comb begin
        w_off         = {PW{1'b0}};
        o_entry_valid = {DEPTH{1'b0}};
        o_entry_rd    = {(DEPTH*REG_AW){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_off            = PW'(i) - r_rd_ptr;
            o_entry_valid[i] = ({1'b0, w_off} < r_count);
            o_entry_rd[i]    = r_mem[i].rd;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_MAX);
    assign o_count = r_count;

endmodule : wb_fifo

// File: rtl/regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue
// Sole writer of the register file's write port. Arbitrates the load unit
// (priority) and the ALU into an in-order FIFO, drops writes to x0, drains
// one entry per cycle into registered write-port outputs, and publishes a
// per-register pending mask for issue-side hazard checks.
//   clk, reset : clock, synchronous active-high reset
//   bus        : regfile_wb_queue_if slave modport (handshakes, write port,
//                pending / count / empty status)
// -----------------------------------------------------------------------------
module regfile_wb_queue
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    regfile_wb_queue_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [REG_AW-1:0] X0 = {REG_AW{1'b0}};

    logic                         w_full;
    logic [CW-1:0]                w_count;
    logic                         w_mem_ready;
    logic                         w_alu_ready;
    logic                         w_mem_fire;
    logic                         w_alu_fire;
    logic                         w_push;
    logic                         w_pop;
    wb_entry_t                    w_push_data;
    wb_entry_t                    w_head;
    logic [DEPTH-1:0]             w_entry_valid;
    logic [DEPTH-1:0][REG_AW-1:0] w_entry_rd;
    logic [NREGS-1:0]             w_pending;

    logic                         r_we;
    logic [REG_AW-1:0]            r_rd;
    logic [XLEN-1:0]              r_rd_value;

    // Readiness looks only at occupancy (no fall-through on a same-cycle pop),
    // so there is no path from alu_valid to either ready.
    assign w_mem_ready = !w_full;
    assign w_alu_ready = !w_full && !bus.mem_valid;
    assign w_mem_fire  = bus.mem_valid && w_mem_ready;
    assign w_alu_fire  = bus.alu_valid && w_alu_ready;
    assign w_pop       = (w_count != {CW{1'b0}}) && !bus.wb_stall;

    // Select the accepted producer; x0 writes are acknowledged but never enqueued.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = '{rd: X0, value: {XLEN{1'b0}}};
        if (w_mem_fire) begin
            w_push      = (bus.mem_rd != X0);
            w_push_data = '{rd: bus.mem_rd, value: bus.mem_value};
        end else if (w_alu_fire) begin
            w_push      = (bus.alu_rd != X0);
            w_push_data = '{rd: bus.alu_rd, value: bus.alu_value};
        end else begin
            w_push      = 1'b0;
        end
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_push),
        .i_data        (w_push_data),
        .i_pop         (w_pop),
        .o_head        (w_head),
        .o_full        (w_full),
        .o_count       (w_count),
        .o_entry_valid (w_entry_valid),
        .o_entry_rd    (w_entry_rd)
    );

    // Write-port registers; address and data hold when nothing is popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_rd       <= X0;
            r_rd_value <= {XLEN{1'b0}};
        end else if (w_pop) begin
            r_we       <= 1'b1;
            r_rd       <= w_head.rd;
            r_rd_value <= w_head.value;
        end else begin
            r_we       <= 1'b0;
        end
    end

    // Pending mask: every queued destination plus the one being presented.
    always_comb begin
        w_pending = {NREGS{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i]) begin
                w_pending = w_pending | onehot_rd(w_entry_rd[i]);
            end else begin
                w_pending = w_pending;
            end
        end
        if (r_we) begin
            w_pending = w_pending | onehot_rd(r_rd);
        end else begin
            w_pending = w_pending;
        end
    end

    assign bus.mem_ready    = w_mem_ready;
    assign bus.alu_ready    = w_alu_ready;
    assign bus.reg_write_en = r_we;
    assign bus.rd           = r_rd;
    assign bus.rd_value     = r_rd_value;
    assign bus.pending      = w_pending;
    assign bus.count        = w_count;
    assign bus.empty        = (w_count == {CW{1'b0}}) && !r_we;

endmodule : regfile_wb_queue
